// File: rtl/scsi_sm_sequencer_pkg.sv
// Shared definitions for the SCSI-side transfer sequencer.
//   state_e    : 5-bit SCSI state register encoding
//   strobes_t  : bundle of combinational control strobes
//   arbitrate(): IDLE arbitration order (CPU read, CPU write, S2F DMA, F2S DMA)
package scsi_sm_pkg;

    typedef enum logic [4:0] {
        IDLE = 5'h00,
        CR1  = 5'h01,
        CR2  = 5'h02,
        CR3  = 5'h03,
        CW1  = 5'h05,
        CW2  = 5'h06,
        CW3  = 5'h07,
        WACK = 5'h08,
        WEND = 5'h09,
        S2F1 = 5'h10,
        S2F2 = 5'h11,
        F2S1 = 5'h14,
        F2S2 = 5'h15
    } state_e;

    typedef struct packed {
        logic scsi_cs;
        logic re;
        logic we;
        logic dack;
        logic cpu2s;
        logic s2cpu;
        logic f2s;
        logic s2f;
        logic incbo;
        logic incni;
        logic incno;
        logic set_dsack;
        logic rdfifo_req;
        logic rififo_req;
    } strobes_t;

    // First match wins; CPU accesses always beat DMA. FIFO flags and pending
    // longword handovers only gate the start of a DMA byte.
    function automatic state_e arbitrate(
        input logic ccpureq,
        input logic rw,
        input logic cdreq_n,
        input logic dmadir,
        input logic fifofull,
        input logic fifoempty,
        input logic rdfifo_o,
        input logic rififo_o
    );
        if (ccpureq && rw)
            return CR1;
        else if (ccpureq)
            return CW1;
        else if (!cdreq_n && !dmadir && !fifofull && !rififo_o)
            return S2F1;
        else if (!cdreq_n && dmadir && !fifoempty && !rdfifo_o)
            return F2S1;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/scsi_sm_sequencer_if.sv
// Request/status and strobe bundle of the SCSI sequencer.
//   slave  : the sequencer (consumes requests/flags, drives STATE and strobes)
//   master : the surrounding CPU/FIFO logic (drives requests/flags)
interface scsi_sm_sequencer_if;
    logic       CCPUREQ;
    logic       RW;
    logic       CDREQ_;
    logic       CDSACK_;
    logic       DMADIR;
    logic       BOEQ3;
    logic       FIFOFULL;
    logic       FIFOEMPTY;
    logic       RDFIFO_o;
    logic       RIFIFO_o;
    logic [4:0] STATE;
    logic       SCSI_CS;
    logic       RE;
    logic       WE;
    logic       DACK;
    logic       CPU2S;
    logic       S2CPU;
    logic       F2S;
    logic       S2F;
    logic       INCBO;
    logic       INCNI;
    logic       INCNO;
    logic       SET_DSACK;
    logic       RDFIFO_REQ;
    logic       RIFIFO_REQ;

    modport slave (
        input  CCPUREQ, RW, CDREQ_, CDSACK_, DMADIR, BOEQ3,
               FIFOFULL, FIFOEMPTY, RDFIFO_o, RIFIFO_o,
        output STATE, SCSI_CS, RE, WE, DACK, CPU2S, S2CPU, F2S, S2F,
               INCBO, INCNI, INCNO, SET_DSACK, RDFIFO_REQ, RIFIFO_REQ
    );

    modport master (
        output CCPUREQ, RW, CDREQ_, CDSACK_, DMADIR, BOEQ3,
               FIFOFULL, FIFOEMPTY, RDFIFO_o, RIFIFO_o,
        input  STATE, SCSI_CS, RE, WE, DACK, CPU2S, S2CPU, F2S, S2F,
               INCBO, INCNI, INCNO, SET_DSACK, RDFIFO_REQ, RIFIFO_REQ
    );
endinterface

// File: rtl/scsi_sm_sequencer_term_decode.sv
// Term decoder: current state + clocked inputs -> next state and strobes.
// Purely combinational; strobes depend on state and BOEQ3 only.
// Inputs : state, ccpureq, rw, cdreq_n, cdsack_n, dmadir, boeq3, fifo flags,
//          pending handover flags
// Outputs: next_state, strb
// Option : SCSI_SM_DSACK_WAIT_EN enables the WACK/WEND termination handshake;
//          when undefined CR3/CW3 return straight to IDLE.
module scsi_sm_term_decode
    import scsi_sm_pkg::*;
(
    input  state_e   state,
    input  logic     ccpureq,
    input  logic     rw,
    input  logic     cdreq_n,
    input  logic     cdsack_n,
    input  logic     dmadir,
    input  logic     boeq3,
    input  logic     fifofull,
    input  logic     fifoempty,
    input  logic     rdfifo_o,
    input  logic     rififo_o,
    output state_e   next_state,
    output strobes_t strb
);

`ifndef SCSI_SM_DSACK_WAIT_EN
    logic unused_cdsack;
    assign unused_cdsack = cdsack_n;
`endif

    always_comb begin
        next_state = IDLE;
        strb       = '0;
        case (state)
            IDLE: next_state = arbitrate(ccpureq, rw, cdreq_n, dmadir,
                                         fifofull, fifoempty, rdfifo_o, rififo_o);
            CR1, CR2, CR3: begin
                strb.scsi_cs = 1'b1;
                strb.re      = 1'b1;
                strb.s2cpu   = 1'b1;
                if (state == CR1) begin
                    next_state = CR2;
                end else if (state == CR2) begin
                    next_state = CR3;
                end else begin
                    strb.set_dsack = 1'b1;
`ifdef SCSI_SM_DSACK_WAIT_EN
                    next_state = WACK;
`else
                    next_state = IDLE;
`endif
                end
            end
            CW1, CW2, CW3: begin
                strb.scsi_cs = 1'b1;
                strb.cpu2s   = 1'b1;
                strb.we      = (state != CW1);
                if (state == CW1) begin
                    next_state = CW2;
                end else if (state == CW2) begin
                    next_state = CW3;
                end else begin
                    strb.set_dsack = 1'b1;
`ifdef SCSI_SM_DSACK_WAIT_EN
                    next_state = WACK;
`else
                    next_state = IDLE;
`endif
                end
            end
`ifdef SCSI_SM_DSACK_WAIT_EN
            WACK: next_state = cdsack_n ? WEND : WACK;
            WEND: next_state = cdsack_n ? WEND : IDLE;
`else
            WACK, WEND: next_state = IDLE;
`endif
            S2F1, S2F2: begin
                strb.dack = 1'b1;
                strb.re   = 1'b1;
                strb.s2f  = 1'b1;
                if (state == S2F1) begin
                    next_state = S2F2;
                end else begin
                    strb.incbo      = 1'b1;
                    strb.incni      = boeq3;
                    strb.rififo_req = boeq3;
                    next_state      = IDLE;
                end
            end
            F2S1, F2S2: begin
                strb.dack = 1'b1;
                strb.f2s  = 1'b1;
                if (state == F2S1) begin
                    next_state = F2S2;
                end else begin
                    strb.we         = 1'b1;
                    strb.incbo      = 1'b1;
                    strb.incno      = boeq3;
                    strb.rdfifo_req = boeq3;
                    next_state      = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/scsi_sm_sequencer.sv
// SCSI-side transfer sequencer top: holds the 5-bit state register only;
// all decoding lives in scsi_sm_term_decode.
// Ports: CPUCLK (state clock), RESET_ (synchronous active-low reset),
//        bus (scsi_sm_sequencer_if.slave: requests/flags in, STATE/strobes out)
// Option: SCSI_SM_DSACK_WAIT_EN (see scsi_sm_term_decode).
module scsi_sm_sequencer
    import scsi_sm_pkg::*;
(
    input  logic                 CPUCLK,
    input  logic                 RESET_,
    scsi_sm_sequencer_if.slave   bus
);

    state_e   state_q;
    state_e   state_d;
    strobes_t strb;

    scsi_sm_term_decode u_term_decode (
        .state      (state_q),
        .ccpureq    (bus.CCPUREQ),
        .rw         (bus.RW),
        .cdreq_n    (bus.CDREQ_),
        .cdsack_n   (bus.CDSACK_),
        .dmadir     (bus.DMADIR),
        .boeq3      (bus.BOEQ3),
        .fifofull   (bus.FIFOFULL),
        .fifoempty  (bus.FIFOEMPTY),
        .rdfifo_o   (bus.RDFIFO_o),
        .rififo_o   (bus.RIFIFO_o),
        .next_state (state_d),
        .strb       (strb)
    );

    always_ff @(posedge CPUCLK) begin
        if (!RESET_)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    assign bus.STATE      = state_q;
    assign bus.SCSI_CS    = strb.scsi_cs;
    assign bus.RE         = strb.re;
    assign bus.WE         = strb.we;
    assign bus.DACK       = strb.dack;
    assign bus.CPU2S      = strb.cpu2s;
    assign bus.S2CPU      = strb.s2cpu;
    assign bus.F2S        = strb.f2s;
    assign bus.S2F        = strb.s2f;
    assign bus.INCBO      = strb.incbo;
    assign bus.INCNI      = strb.incni;
    assign bus.INCNO      = strb.incno;
    assign bus.SET_DSACK  = strb.set_dsack;
    assign bus.RDFIFO_REQ = strb.rdfifo_req;
    assign bus.RIFIFO_REQ = strb.rififo_req;

endmodule

// File: tb/tb_scsi_sm_sequencer.sv
// Bench for scsi_sm_sequencer: directed scenarios with literal expectations,
// then randomized stimulus; a transaction-level model is compared every cycle.
module tb_scsi_sm_sequencer;

`ifdef SCSI_SM_DSACK_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    scsi_sm_sequencer_if bus();

    scsi_sm_sequencer dut (
        .CPUCLK (clk),
        .RESET_ (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Actual strobes packed in a fixed order shared with exp_strb().
    function automatic logic [13:0] act_strb();
        return {bus.SCSI_CS, bus.RE, bus.WE, bus.DACK, bus.CPU2S, bus.S2CPU,
                bus.F2S, bus.S2F, bus.INCBO, bus.INCNI, bus.INCNO,
                bus.SET_DSACK, bus.RDFIFO_REQ, bus.RIFIFO_REQ};
    endfunction

    // Strobe rules written out per state code.
    function automatic logic [13:0] exp_strb(input logic [4:0] s, input logic b);
        logic rd, wr, sf, fs;
        rd = (s >= 5'h01 && s <= 5'h03);
        wr = (s >= 5'h05 && s <= 5'h07);
        sf = (s == 5'h10 || s == 5'h11);
        fs = (s == 5'h14 || s == 5'h15);
        return {rd | wr, rd | sf, (s == 5'h06 || s == 5'h07 || s == 5'h15),
                sf | fs, wr, rd, fs, sf, (s == 5'h11 || s == 5'h15),
                (s == 5'h11) & b, (s == 5'h15) & b, (s == 5'h03 || s == 5'h07),
                (s == 5'h15) & b, (s == 5'h11) & b};
    endfunction

    // Transaction model: a started transfer enqueues its whole state sequence.
    logic [4:0] m_state;
    bit         m_valid = 1'b0;
    logic [4:0] seq_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            seq_q.delete();
            m_state = 5'h00;
            m_valid = 1'b1;
        end else if (seq_q.size() != 0) begin
            m_state = seq_q.pop_front();
        end else if (m_state == 5'h08) begin
            if (bus.CDSACK_) m_state = 5'h09;
        end else if (m_state == 5'h09) begin
            if (!bus.CDSACK_) m_state = 5'h00;
        end else begin
            m_state = 5'h00;
            if (bus.CCPUREQ) begin
                m_state = bus.RW ? 5'h01 : 5'h05;
                seq_q.push_back(m_state + 5'd1);
                seq_q.push_back(m_state + 5'd2);
                seq_q.push_back(WAIT_EN ? 5'h08 : 5'h00);
            end else if (!bus.CDREQ_ && !bus.DMADIR && !bus.FIFOFULL && !bus.RIFIFO_o) begin
                m_state = 5'h10;
                seq_q.push_back(5'h11);
                seq_q.push_back(5'h00);
            end else if (!bus.CDREQ_ && bus.DMADIR && !bus.FIFOEMPTY && !bus.RDFIFO_o) begin
                m_state = 5'h14;
                seq_q.push_back(5'h15);
                seq_q.push_back(5'h00);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (bus.STATE !== m_state || act_strb() !== exp_strb(m_state, bus.BOEQ3)) begin
                failures++;
                $display("FAIL model_cmp t=%0t state=%h strobes=%b required state=%h strobes=%b",
                         $time, bus.STATE, act_strb(), m_state, exp_strb(m_state, bus.BOEQ3));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic finish_cpu(input string name);
        if (WAIT_EN) begin
            step();
            chk({name, "_wack"}, 32'(bus.STATE), 32'h08);
            bus.CDSACK_ = 1'b1;
            step();
            chk({name, "_wend"}, 32'(bus.STATE), 32'h09);
            bus.CDSACK_ = 1'b0;
        end
        step();
        chk({name, "_idle"}, 32'(bus.STATE), 32'h00);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.CCPUREQ   = 1'b1;
        bus.RW        = 1'b1;
        bus.CDREQ_    = 1'b1;
        bus.CDSACK_   = 1'b0;
        bus.DMADIR    = 1'b0;
        bus.BOEQ3     = 1'b0;
        bus.FIFOFULL  = 1'b0;
        bus.FIFOEMPTY = 1'b0;
        bus.RDFIFO_o  = 1'b0;
        bus.RIFIFO_o  = 1'b0;

        // Reset held with a CPU request pending.
        step();
        step();
        chk("rst_state", 32'(bus.STATE), 32'h00);
        chk("rst_strobes", 32'(act_strb()), 32'h0);
        rst_n = 1'b1;

        // CPU read.
        step();
        chk("cr1_state", 32'(bus.STATE), 32'h01);
        chk("cr1_re", 32'(bus.RE), 32'h1);
        bus.CCPUREQ = 1'b0;
        step();
        chk("cr2_state", 32'(bus.STATE), 32'h02);
        chk("cr2_dsack", 32'(bus.SET_DSACK), 32'h0);
        step();
        chk("cr3_re", 32'(bus.RE), 32'h1);
        chk("cr3_dsack", 32'(bus.SET_DSACK), 32'h1);
        finish_cpu("cpu_rd");

        // CPU write.
        bus.CCPUREQ = 1'b1;
        bus.RW      = 1'b0;
        step();
        chk("cw1_state", 32'(bus.STATE), 32'h05);
        chk("cw1_cpu2s_we_s2cpu", 32'({bus.CPU2S, bus.WE, bus.S2CPU}), 32'b100);
        bus.CCPUREQ = 1'b0;
        step();
        chk("cw2_cpu2s_we_s2cpu", 32'({bus.CPU2S, bus.WE, bus.S2CPU}), 32'b110);
        step();
        chk("cw3_we_dsack_s2cpu", 32'({bus.WE, bus.SET_DSACK, bus.S2CPU}), 32'b110);
        finish_cpu("cpu_wr");

        // S2F byte with BOEQ3=1.
        bus.CDREQ_ = 1'b0;
        bus.DMADIR = 1'b0;
        bus.BOEQ3  = 1'b1;
        step();
        chk("s2f1_state", 32'(bus.STATE), 32'h10);
        chk("s2f1_dack_re_incbo", 32'({bus.DACK, bus.RE, bus.INCBO}), 32'b110);
        bus.CDREQ_ = 1'b1;
        step();
        chk("s2f2_strobes", 32'({bus.DACK, bus.RE, bus.INCBO, bus.INCNI, bus.RIFIFO_REQ}), 32'b11111);
        step();
        chk("s2f_done", 32'(bus.STATE), 32'h00);

        // F2S blocked by empty FIFO, then allowed with BOEQ3=0.
        bus.CDREQ_    = 1'b0;
        bus.DMADIR    = 1'b1;
        bus.FIFOEMPTY = 1'b1;
        bus.BOEQ3     = 1'b0;
        step();
        step();
        chk("f2s_blocked", 32'(bus.STATE), 32'h00);
        bus.FIFOEMPTY = 1'b0;
        step();
        chk("f2s1_state", 32'(bus.STATE), 32'h14);
        bus.CDREQ_ = 1'b1;
        step();
        chk("f2s2_we_incbo_incno", 32'({bus.WE, bus.INCBO, bus.INCNO}), 32'b110);
        step();
        chk("f2s_done", 32'(bus.STATE), 32'h00);

        // Simultaneous CPU and DMA request: CPU first, DMA after.
        bus.CCPUREQ = 1'b1;
        bus.RW      = 1'b1;
        bus.CDREQ_  = 1'b0;
        bus.DMADIR  = 1'b0;
        step();
        chk("both_cpu_wins", 32'(bus.STATE), 32'h01);
        bus.CCPUREQ = 1'b0;
        step();
        step();
        finish_cpu("both");
        step();
        chk("both_dma_after", 32'(bus.STATE), 32'h10);

        // Reset mid-transfer.
        rst_n = 1'b0;
        step();
        chk("abort_state", 32'(bus.STATE), 32'h00);
        chk("abort_strobes", 32'(act_strb()), 32'h0);
        rst_n = 1'b1;
        bus.CDREQ_ = 1'b1;
        step();
        chk("abort_stay_idle", 32'(bus.STATE), 32'h00);

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            bus.CCPUREQ   = ($urandom_range(0, 5) == 0);
            bus.RW        = $urandom_range(0, 1) == 1;
            bus.CDREQ_    = $urandom_range(0, 1) == 1;
            bus.CDSACK_   = $urandom_range(0, 1) == 1;
            bus.DMADIR    = $urandom_range(0, 1) == 1;
            bus.BOEQ3     = $urandom_range(0, 1) == 1;
            bus.FIFOFULL  = ($urandom_range(0, 3) == 0);
            bus.FIFOEMPTY = ($urandom_range(0, 3) == 0);
            bus.RDFIFO_o  = ($urandom_range(0, 3) == 0);
            bus.RIFIFO_o  = ($urandom_range(0, 3) == 0);
            step();
        end

        @(posedge clk);
        #7;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
